// File: rtl/aes_pkg.sv
// Shared AES definitions for the decryption key scheduler: state encoding,
// block/word sizes, the S-box table, Rcon lookup and a GF(2^8) multiply helper.
package aes_pkg;

   localparam int AES_NUM_ROUNDS_128 = 10;
   localparam int AES_BLOCK_W        = 128;
   localparam int AES_WORD_W         = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      EXPAND = 2'd1,
      OUTPUT = 2'd2
   } aes_state_e;

   // Forward S-box, entry 0x00 in the most significant byte
   localparam logic [2047:0] SBOX_TABLE = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox_lookup(input logic [7:0] b);
      logic [10:0] base;
      base = {b, 3'b000};
      return SBOX_TABLE[11'd2047 - base -: 8];
   endfunction

   function automatic logic [AES_WORD_W-1:0] rcon(input logic [3:0] round);
      logic [7:0] rc;
      case (round)
         4'd1:    rc = 8'h01;
         4'd2:    rc = 8'h02;
         4'd3:    rc = 8'h04;
         4'd4:    rc = 8'h08;
         4'd5:    rc = 8'h10;
         4'd6:    rc = 8'h20;
         4'd7:    rc = 8'h40;
         4'd8:    rc = 8'h80;
         4'd9:    rc = 8'h1b;
         4'd10:   rc = 8'h36;
         default: rc = 8'h00;
      endcase
      return {rc, 24'h000000};
   endfunction

   // Multiply by a 4-bit constant in GF(2^8); enough for (Inv)MixColumns
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [3:0] c);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 4; i++) begin
         if (c[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

endpackage

// File: rtl/aes_columns_mixer.sv
// MixColumns (Encrypt=1) or InvMixColumns (Encrypt=0) over a 128-bit state,
// column c in bits [127-32c -: 32], row r of a column in [31-8r -: 8].
module aes_columns_mixer
   import aes_pkg::*;
(
   input  logic                   Encrypt,
   input  logic [AES_BLOCK_W-1:0] data,
   output logic [AES_BLOCK_W-1:0] mixed
);

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_col
         logic [AES_WORD_W-1:0] col_in;
         logic [AES_WORD_W-1:0] col_out;
         logic [15:0]           coef;

         assign col_in = data[AES_BLOCK_W-1-AES_WORD_W*gi -: AES_WORD_W];
         assign coef   = Encrypt ? 16'h2311 : 16'hebd9;

         // circulant matrix: row r = sum over k of coef[k] * a[(r+k) mod 4]
         always_comb begin
            col_out = '0;
            for (int r = 0; r < 4; r++) begin
               for (int k = 0; k < 4; k++) begin
                  col_out[31-8*r -: 8] = col_out[31-8*r -: 8]
                     ^ gf_mul(col_in[31-8*((r+k)%4) -: 8], coef[15-4*k -: 4]);
               end
            end
         end

         assign mixed[AES_BLOCK_W-1-AES_WORD_W*gi -: AES_WORD_W] = col_out;
      end
   endgenerate

endmodule

// File: rtl/aes_sbox.sv
// Single combinational AES forward S-box.
module aes_sbox
   import aes_pkg::*;
(
   input  logic [7:0] data,
   output logic [7:0] sub
);

   assign sub = sbox_lookup(data);

endmodule

// File: rtl/aes_sub_word.sv
// 32-bit SubWord: four parallel S-boxes, one per byte.
module aes_sub_word
   import aes_pkg::*;
(
   input  logic [AES_WORD_W-1:0] word,
   output logic [AES_WORD_W-1:0] sub
);

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_sbox
         aes_sbox u_sbox (
            .data (word[8*gi +: 8]),
            .sub  (sub[8*gi +: 8])
         );
      end
   endgenerate

endmodule

// File: rtl/aes_dec_key_scheduler.sv
// AES-128 decryption key scheduler: expands forward to round 10, then streams
// round keys 10..0 by undoing one expansion step per accepted key.
module aes_dec_key_scheduler
   import aes_pkg::*;
#(
   parameter bit EQUIV_INV = 1'b0
) (
   input  logic                   Clk,
   input  logic                   Rst_n,
   input  logic [AES_BLOCK_W-1:0] Key,
   input  logic                   Key_valid,
   output logic                   Key_ready,
   output logic [AES_BLOCK_W-1:0] Round_key,
   output logic [3:0]             Round_key_idx,
   output logic                   Round_key_valid,
   output logic                   Round_key_last,
   input  logic                   Round_key_ready
);

   localparam logic [3:0] LAST_ROUND = 4'(AES_NUM_ROUNDS_128);

   aes_state_e             state_reg;
   logic [AES_BLOCK_W-1:0] rk_reg;
   logic [3:0]             ctr_reg;
   logic [3:0]             idx_reg;
   logic                   valid_reg;

   logic [AES_WORD_W-1:0]  w [4];
   logic [AES_WORD_W-1:0]  w3_prev;
   logic [AES_WORD_W-1:0]  sub_src;
   logic [AES_WORD_W-1:0]  sub_out;
   logic [AES_WORD_W-1:0]  rcon_word;
   logic [AES_WORD_W-1:0]  w0_step;
   logic [AES_WORD_W-1:0]  f1;
   logic [AES_WORD_W-1:0]  f2;
   logic [AES_WORD_W-1:0]  f3;
   logic [AES_BLOCK_W-1:0] fwd_next;
   logic [AES_BLOCK_W-1:0] bwd_next;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_words
         assign w[gi] = rk_reg[AES_BLOCK_W-1-AES_WORD_W*gi -: AES_WORD_W];
      end
   endgenerate

   // One SubWord path: forward reads w3, backward reads the recovered w3 = w2^w3
   assign w3_prev   = w[3] ^ w[2];
   assign sub_src   = (state_reg == EXPAND) ? w[3] : w3_prev;
   assign rcon_word = rcon((state_reg == EXPAND) ? ctr_reg : idx_reg);

   aes_sub_word u_sub_word (
      .word ({sub_src[23:0], sub_src[31:24]}),
      .sub  (sub_out)
   );

   assign w0_step  = w[0] ^ sub_out ^ rcon_word;
   assign f1       = w[1] ^ w0_step;
   assign f2       = w[2] ^ f1;
   assign f3       = w[3] ^ f2;
   assign fwd_next = {w0_step, f1, f2, f3};
   assign bwd_next = {w0_step, w[1] ^ w[0], w[2] ^ w[1], w3_prev};

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_reg <= IDLE;
         rk_reg    <= '0;
         ctr_reg   <= '0;
         idx_reg   <= '0;
         valid_reg <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (Key_valid) begin
                  rk_reg    <= Key;
                  ctr_reg   <= 4'd1;
                  state_reg <= EXPAND;
               end
            end
            EXPAND: begin
               rk_reg <= fwd_next;
               if (ctr_reg == LAST_ROUND) begin
                  ctr_reg   <= '0;
                  idx_reg   <= LAST_ROUND;
                  valid_reg <= 1'b1;
                  state_reg <= OUTPUT;
               end else begin
                  ctr_reg <= ctr_reg + 4'd1;
               end
            end
            OUTPUT: begin
               if (Round_key_ready) begin
                  if (idx_reg != 4'd0) begin
                     rk_reg  <= bwd_next;
                     idx_reg <= idx_reg - 4'd1;
                  end else begin
                     valid_reg <= 1'b0;
                     state_reg <= IDLE;
                  end
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign Key_ready       = (state_reg == IDLE);
   assign Round_key_valid = valid_reg;
   assign Round_key_idx   = idx_reg;
   assign Round_key_last  = valid_reg && (idx_reg == 4'd0);

   // rk_reg stays raw; only the outgoing view of rounds 9..1 is transformed
   generate
      if (EQUIV_INV) begin : g_equiv
         logic [AES_BLOCK_W-1:0] imc_key;
         logic                   mid_round;

         aes_columns_mixer u_mixer (
            .Encrypt (1'b0),
            .data    (rk_reg),
            .mixed   (imc_key)
         );

         assign mid_round = (idx_reg != 4'd0) && (idx_reg != LAST_ROUND);
         assign Round_key = mid_round ? imc_key : rk_reg;
      end else begin : g_raw
         assign Round_key = rk_reg;
      end
   endgenerate

endmodule

// File: tb/tb_aes_dec_key_scheduler.sv
// Scoreboard bench for aes_dec_key_scheduler: raw and equivalent-inverse
// instances share stimulus and are checked against a FIPS-197 style model.
module tb_aes_dec_key_scheduler;

   localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] KEY_B    = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] KEY_B_R10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

   logic         Clk;
   logic         Rst_n;
   logic [127:0] Key;
   logic         Key_valid;
   logic         Round_key_ready;

   logic         kr0, v0, last0, kr1, v1, last1;
   logic [127:0] rk0, rk1;
   logic [3:0]   idx0, idx1;

   int total = 0;
   int bad   = 0;

   typedef struct {
      int           idx;
      logic [127:0] key;
   } exp_t;

   exp_t         q0[$];
   exp_t         q1[$];
   logic [7:0]   sbox_t [256];
   logic [127:0] gold [11];
   bit           pend [2];

   aes_dec_key_scheduler #(.EQUIV_INV(1'b0)) dut_raw (
      .Clk(Clk), .Rst_n(Rst_n), .Key(Key), .Key_valid(Key_valid), .Key_ready(kr0),
      .Round_key(rk0), .Round_key_idx(idx0), .Round_key_valid(v0),
      .Round_key_last(last0), .Round_key_ready(Round_key_ready)
   );

   aes_dec_key_scheduler #(.EQUIV_INV(1'b1)) dut_equiv (
      .Clk(Clk), .Rst_n(Rst_n), .Key(Key), .Key_valid(Key_valid), .Key_ready(kr1),
      .Round_key(rk1), .Round_key_idx(idx1), .Round_key_valid(v1),
      .Round_key_last(last1), .Round_key_ready(Round_key_ready)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // ---------------- reference model ----------------
   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xt(x);
      end
      return p;
   endfunction

   // S-box from its definition: multiplicative inverse then affine map
   task automatic build_sbox();
      for (int x = 0; x < 256; x++) begin
         logic [7:0] inv = 8'h00;
         logic [7:0] s;
         logic [7:0] t;
         if (x != 0)
            for (int y = 1; y < 256; y++)
               if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         s = inv;
         t = inv;
         for (int r = 0; r < 4; r++) begin
            t = {t[6:0], t[7]};
            s = s ^ t;
         end
         sbox_t[x] = s ^ 8'h63;
      end
   endtask

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
   endfunction

   task automatic expand(input logic [127:0] k);
      logic [31:0] w [44];
      logic [31:0] t;
      logic [7:0]  rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            rc = xt(rc);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r < 11; r++) gold[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   function automatic logic [127:0] inv_mix(input logic [127:0] s);
      logic [127:0] o = '0;
      logic [7:0]   cf [4];
      cf[0] = 8'h0e; cf[1] = 8'h0b; cf[2] = 8'h0d; cf[3] = 8'h09;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++) begin
            logic [7:0] acc = 8'h00;
            for (int k = 0; k < 4; k++)
               acc = acc ^ gm(s[127-32*c-8*((r+k)%4) -: 8], cf[k]);
            o[127-32*c-8*r -: 8] = acc;
         end
      return o;
   endfunction

   task automatic push_expected(input logic [127:0] k);
      exp_t e;
      expand(k);
      for (int r = 10; r >= 0; r--) begin
         e.idx = r;
         e.key = gold[r];
         q0.push_back(e);
         if (r >= 1 && r <= 9) e.key = inv_mix(gold[r]);
         q1.push_back(e);
      end
   endtask

   // ---------------- checking helpers ----------------
   task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, got, want);
      end
   endtask

   task automatic timeout(input string name);
      total++;
      bad++;
      $display("FAIL %s: timed out waiting for DUT", name);
   endtask

   task automatic mon_chk(input int w, input logic v, input logic [3:0] idx,
                          input logic [127:0] rk, input logic last);
      exp_t e;
      int   qs;
      qs = (w == 0) ? q0.size() : q1.size();
      if (v) begin
         total++;
         if (qs == 0) begin
            bad++;
            $display("FAIL unexpected_valid dut%0d: idx %0d key %h with nothing expected", w, idx, rk);
         end else begin
            e = (w == 0) ? q0[0] : q1[0];
            if (rk !== e.key || idx !== 4'(e.idx) || last !== (e.idx == 0)) begin
               bad++;
               $display("FAIL round_key dut%0d: got idx %0d key %h last %b expected idx %0d key %h last %b",
                        w, idx, rk, last, e.idx, e.key, e.idx == 0);
            end
            if (Round_key_ready) begin
               if (w == 0) void'(q0.pop_front());
               else        void'(q1.pop_front());
               $display("handshake dut%0d idx=%0d key=%h last=%b", w, idx, rk, last);
            end
         end
      end else if (last) begin
         chk($sformatf("last_without_valid dut%0d", w), 128'(last), 128'(0));
      end
      if (pend[w] && !v) begin
         total++;
         bad++;
         $display("FAIL valid_dropped dut%0d: valid 0 expected 1 (no handshake)", w);
      end
      pend[w] = v && !Round_key_ready;
   endtask

   always @(negedge Clk) begin
      if (!Rst_n) begin
         pend[0] = 1'b0;
         pend[1] = 1'b0;
      end else begin
         mon_chk(0, v0, idx0, rk0, last0);
         mon_chk(1, v1, idx1, rk1, last1);
      end
   end

   // ---------------- stimulus ----------------
   task automatic send_key(input logic [127:0] k, input bit rnd);
      int g = 0;
      while (!kr0 && g < 200) begin
         if (rnd) Round_key_ready = ($urandom_range(0, 3) != 0);
         @(posedge Clk); #1;
         g++;
      end
      if (!kr0) timeout("send_key");
      Key       = k;
      Key_valid = 1'b1;
      push_expected(k);
      @(posedge Clk); #1;
      Key_valid = 1'b0;
   endtask

   task automatic wait_out(input int want);
      bit ok = 1'b0;
      for (int g = 0; g < 60; g++) begin
         if (v0 && idx0 == 4'(want)) begin
            ok = 1'b1;
            break;
         end
         @(posedge Clk); #1;
      end
      if (!ok) timeout($sformatf("wait_idx%0d", want));
   endtask

   task automatic wait_idle(input bit rnd);
      for (int g = 0; g < 300; g++) begin
         if (kr0) break;
         if (rnd) Round_key_ready = ($urandom_range(0, 3) != 0);
         @(posedge Clk); #1;
      end
      if (!kr0) timeout("wait_idle");
      Round_key_ready = 1'b1;
   endtask

   initial begin
      int lat;
      Rst_n = 1'b0;
      Key = '0;
      Key_valid = 1'b0;
      Round_key_ready = 1'b0;
      build_sbox();

      // reset state
      repeat (3) @(posedge Clk);
      #1;
      chk("rst_valid", 128'(v0), 128'(0));
      chk("rst_last", 128'(last0), 128'(0));
      chk("rst_key", rk0, 128'(0));
      chk("rst_idx", 128'(idx0), 128'(0));
      chk("rst_key_ready", 128'(kr0), 128'(1));
      chk("rst_valid_equiv", 128'(v1), 128'(0));
      Rst_n = 1'b1;
      @(posedge Clk); #1;

      // FIPS-197 sequence, ready held high
      Round_key_ready = 1'b1;
      send_key(FIPS_KEY, 1'b0);
      lat = 0;
      while (!v0 && lat < 30) begin
         @(posedge Clk); #1;
         lat++;
      end
      chk("latency_edges", 128'(lat), 128'(10));
      chk("fips_idx10_key", rk0, FIPS_R10);
      chk("fips_idx10_idx", 128'(idx0), 128'(10));
      chk("equiv_idx10_raw", rk1, FIPS_R10);
      wait_out(1);
      chk("fips_idx1_key", rk0, FIPS_R1);
      chk("equiv_idx1_imc", rk1, inv_mix(FIPS_R1));
      @(posedge Clk); #1;
      chk("fips_idx0_idx", 128'(idx0), 128'(0));
      chk("fips_idx0_key", rk0, FIPS_KEY);
      chk("fips_idx0_last", 128'(last0), 128'(1));
      chk("equiv_idx0_raw", rk1, FIPS_KEY);
      @(posedge Clk); #1;
      chk("fips_key_ready_after", 128'(kr0), 128'(1));
      chk("fips_valid_after", 128'(v0), 128'(0));

      // back-to-back sessions
      send_key(FIPS_KEY, 1'b0);
      send_key(KEY_B, 1'b0);
      wait_out(10);
      chk("b2b_idx10_key", rk0, KEY_B_R10);
      wait_idle(1'b0);

      // backpressure at idx 7
      send_key(FIPS_KEY, 1'b0);
      wait_out(7);
      Round_key_ready = 1'b0;
      repeat (5) begin
         @(posedge Clk); #1;
         chk("bp_valid", 128'(v0), 128'(1));
         chk("bp_idx", 128'(idx0), 128'(7));
         chk("bp_key", rk0, gold[7]);
      end
      Round_key_ready = 1'b1;
      wait_idle(1'b0);

      // Key_valid held high during a session
      send_key(FIPS_KEY, 1'b0);
      Key = {$urandom, $urandom, $urandom, $urandom};
      Key_valid = 1'b1;
      for (int g = 0; g < 40; g++) begin
         chk("kv_held_key_ready", 128'(kr0), 128'(0));
         if (v0 && last0) break;
         @(posedge Clk); #1;
      end
      @(posedge Clk); #1;
      Key_valid = 1'b0;
      chk("kv_held_idle_ready", 128'(kr0), 128'(1));
      repeat (3) begin
         @(posedge Clk); #1;
         chk("kv_held_no_session", 128'(v0), 128'(0));
      end

      // reset during OUTPUT at idx 4
      send_key(FIPS_KEY, 1'b0);
      wait_out(4);
      Rst_n = 1'b0;
      q0.delete();
      q1.delete();
      #1;
      chk("midrst_valid", 128'(v0), 128'(0));
      chk("midrst_last", 128'(last0), 128'(0));
      chk("midrst_key", rk0, 128'(0));
      chk("midrst_idx", 128'(idx0), 128'(0));
      chk("midrst_key_ready", 128'(kr0), 128'(1));
      chk("midrst_equiv_key", rk1, 128'(0));
      repeat (3) @(posedge Clk);
      #1;
      Rst_n = 1'b1;
      repeat (5) begin
         @(posedge Clk); #1;
         chk("postrst_no_valid", 128'(v0), 128'(0));
      end
      send_key(FIPS_KEY, 1'b0);
      wait_out(10);
      chk("reload_idx10_key", rk0, FIPS_R10);
      wait_idle(1'b0);

      // randomized keys with random backpressure
      for (int s = 0; s < 6; s++) begin
         send_key({$urandom, $urandom, $urandom, $urandom}, 1'b1);
         wait_idle(1'b1);
      end

      repeat (3) @(posedge Clk);
      #1;
      chk("raw_queue_drained", 128'(q0.size()), 128'(0));
      chk("equiv_queue_drained", 128'(q1.size()), 128'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
